// File: rtl/mem_stage.sv
// Memory-access stage: ALU/CMP write-back pass-through plus LDW/STR through a
// req/ack data-memory port. EX is stalled while a memory access is pending and
// a missing ack aborts the access after TIMEOUT request cycles, flagging mem_err.
module mem_stage #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [4:0]        ex_opcode,
  input  logic [31:0]       ex_data,
  input  logic [31:0]       ex_sdata,
  input  logic [3:0]        ex_dest,
  output logic              stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  input  logic              dm_ack,
  output logic              wb_en,
  output logic [3:0]        wb_addr,
  output logic [31:0]       wb_data,
  output logic              mem_err
);

  // Opcode encodings of the PIGRO ISA; 16..31 are undefined.
  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_ARSH = 5'd9;   // last ALU op (ADD..ARSH = 1..9)
  localparam logic [4:0] OP_CMP  = 5'd10;
  localparam logic [4:0] OP_LDW  = 5'd14;
  localparam logic [4:0] OP_STR  = 5'd15;

  // Abort fires on the edge the counter would reach TIMEOUT, so dm_req is
  // held for exactly TIMEOUT cycles when no ack ever arrives.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state, state_nx;
  logic [7:0]  cnt;
  logic [3:0]  ld_dest;
  logic        accept, is_alu, is_cmp, is_mem, tmo;

  assign stall  = (state == ACCESS);
  assign accept = ex_valid && (state == IDLE);
  assign is_alu = (ex_opcode > OP_NOP) && (ex_opcode <= OP_ARSH);
  assign is_cmp = (ex_opcode == OP_CMP);
  assign is_mem = (ex_opcode == OP_LDW) || (ex_opcode == OP_STR);
  assign tmo    = (state == ACCESS) && !dm_ack && (cnt == CNT_LAST);

  // Next-state: enter ACCESS on an accepted LDW/STR, leave on ack or timeout.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && is_mem) state_nx = ACCESS;
      ACCESS:  if (dm_ack || tmo)    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Registered outputs: write-back pulse, memory request, timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      ld_dest  <= '0;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      wb_en    <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      mem_err  <= 1'b0;
    end else begin
      wb_en <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) begin
            if (is_alu || is_cmp) begin
              wb_en   <= 1'b1;
              wb_addr <= ex_dest;
              wb_data <= is_cmp ? {30'b0, ex_data[1:0]} : ex_data;
            end
            if (is_mem) begin
              dm_req   <= 1'b1;
              dm_we    <= (ex_opcode == OP_STR);
              dm_addr  <= ex_data[ADDR_W-1:0];
              dm_wdata <= ex_sdata;
              ld_dest  <= ex_dest;
            end
          end
        end
        ACCESS: begin
          if (dm_ack) begin
            dm_req <= 1'b0;
            dm_we  <= 1'b0;
            if (!dm_we) begin
              wb_en   <= 1'b1;
              wb_addr <= ld_dest;
              wb_data <= dm_rdata;
            end
          end else if (tmo) begin
            dm_req  <= 1'b0;
            dm_we   <= 1'b0;
            mem_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed stimulus pushes expected write-backs and memory
// requests into queues; monitors pop and compare when the DUT presents them.
module tb_mem_stage;

  localparam logic [4:0] ADD = 5'd1;
  localparam logic [4:0] CMP = 5'd10;
  localparam logic [4:0] BRQ = 5'd11;
  localparam logic [4:0] NOP = 5'd0;
  localparam logic [4:0] LDW = 5'd14;
  localparam logic [4:0] STR = 5'd15;

  logic        clk = 0, rst = 1;
  logic        ex_valid = 0;
  logic [4:0]  ex_opcode = 0;
  logic [31:0] ex_data = 0, ex_sdata = 0;
  logic [3:0]  ex_dest = 0;
  logic        stall, dm_req, dm_we;
  logic [7:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata = 0;
  logic        dm_ack = 0;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mem_err;

  int total = 0, bad = 0;

  typedef struct { logic [3:0] a; logic [31:0] d; } wb_t;
  typedef struct { logic we; logic [7:0] addr; logic [31:0] wdata; } mr_t;
  wb_t wbq[$];
  mr_t mrq[$];

  mem_stage #(.ADDR_W(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_data(ex_data), .ex_sdata(ex_sdata), .ex_dest(ex_dest),
    .stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] d,
                       input logic [31:0] sd, input logic [3:0] dst);
    ex_valid = 1; ex_opcode = op; ex_data = d; ex_sdata = sd; ex_dest = dst;
    tick();
    ex_valid = 0;
  endtask

  // Write-back monitor: every wb_en pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && wb_en) begin
      if (wbq.size() == 0) begin
        chk("wb_unexpected", {28'b0, wb_addr}, 32'hFFFF_FFFF);
      end else begin
        wb_t e;
        e = wbq.pop_front();
        chk("wb_addr", {28'b0, wb_addr}, {28'b0, e.a});
        chk("wb_data", wb_data, e.d);
      end
    end
  end

  // Memory-request monitor: compare each new request on its first cycle.
  logic req_prev = 0;
  always @(negedge clk) begin
    if (!rst && dm_req && !req_prev) begin
      if (mrq.size() == 0) begin
        chk("req_unexpected", {24'b0, dm_addr}, 32'hFFFF_FFFF);
      end else begin
        mr_t m;
        m = mrq.pop_front();
        chk("dm_we", {31'b0, dm_we}, {31'b0, m.we});
        chk("dm_addr", {24'b0, dm_addr}, {24'b0, m.addr});
        if (m.we) chk("dm_wdata", dm_wdata, m.wdata);
      end
    end
    req_prev = dm_req;
  end

  initial begin
    int n;
    // Reset state
    tick(); tick();
    @(negedge clk);
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_req", {31'b0, dm_req}, 0);
    chk("rst_wb_en", {31'b0, wb_en}, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_mem_err", {31'b0, mem_err}, 0);
    rst = 0;
    tick();

    // 1: ADD -> write-back next cycle, no stall
    wbq.push_back('{4'd3, 32'h7});
    issue(ADD, 32'h7, 0, 4'd3);
    @(negedge clk);
    chk("add_wb_en", {31'b0, wb_en}, 1);
    chk("add_stall", {31'b0, stall}, 0);
    tick();

    // 2: STR, ack in the third request cycle
    mrq.push_back('{1'b1, 8'h10, 32'hDEADBEEF});
    issue(STR, 32'h10, 32'hDEADBEEF, 4'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("str_req_held", {31'b0, dm_req}, 1);
      chk("str_addr_held", {24'b0, dm_addr}, 32'h10);
      chk("str_data_held", dm_wdata, 32'hDEADBEEF);
      chk("str_stall", {31'b0, stall}, 1);
      if (i == 2) dm_ack = 1;
      tick();
      dm_ack = 0;
    end
    @(negedge clk);
    chk("str_req_drop", {31'b0, dm_req}, 0);
    chk("str_stall_drop", {31'b0, stall}, 0);
    tick();

    // 3: LDW, ack on the first request cycle
    mrq.push_back('{1'b0, 8'h22, 32'h0});
    wbq.push_back('{4'd5, 32'h12345678});
    issue(LDW, 32'h22, 0, 4'd5);
    @(negedge clk);
    chk("ldw_stall", {31'b0, stall}, 1);
    dm_ack = 1; dm_rdata = 32'h12345678;
    tick();
    dm_ack = 0; dm_rdata = 0;
    @(negedge clk);
    chk("ldw_stall_1cyc", {31'b0, stall}, 0);
    chk("ldw_wb_en", {31'b0, wb_en}, 1);
    tick();

    // 4: LDW without ack -> abort after TIMEOUT request cycles
    mrq.push_back('{1'b0, 8'h30, 32'h0});
    issue(LDW, 32'h30, 0, 4'd1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!dm_req) break;
      if (i == 0) chk("tmo_err_before", {31'b0, mem_err}, 0);
      n++;
    end
    chk("tmo_req_cycles", n, 15);
    chk("tmo_mem_err", {31'b0, mem_err}, 1);
    chk("tmo_stall", {31'b0, stall}, 0);
    tick();
    wbq.push_back('{4'd2, 32'hAB});
    issue(ADD, 32'hAB, 0, 4'd2);
    @(negedge clk);
    chk("tmo_next_alu", {31'b0, wb_en}, 1);
    chk("tmo_err_sticky", {31'b0, mem_err}, 1);
    tick();

    // 5: reset two cycles into an LDW wait, then a late ack
    mrq.push_back('{1'b0, 8'h40, 32'h0});
    issue(LDW, 32'h40, 0, 4'd6);
    @(negedge clk); @(negedge clk);
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("rstmid_req", {31'b0, dm_req}, 0);
    chk("rstmid_stall", {31'b0, stall}, 0);
    chk("rstmid_err", {31'b0, mem_err}, 0);
    chk("rstmid_addr", {24'b0, dm_addr}, 0);
    dm_ack = 1; dm_rdata = 32'hCAFEF00D;
    tick();
    dm_ack = 0; dm_rdata = 0;
    @(negedge clk);
    chk("late_ack_no_wb", {31'b0, wb_en}, 0);
    tick();

    // 6: stream ADD, CMP, BRQ, NOP, undefined -> write-back for ADD and CMP only
    wbq.push_back('{4'd1, 32'h11});
    wbq.push_back('{4'd2, 32'h2});
    ex_valid = 1;
    ex_opcode = ADD; ex_data = 32'h11; ex_dest = 4'd1; tick();
    chk("stream_stall0", {31'b0, stall}, 0);
    ex_opcode = CMP; ex_data = 32'h2;  ex_dest = 4'd2; tick();
    chk("stream_stall1", {31'b0, stall}, 0);
    ex_opcode = BRQ; ex_data = 32'h55; ex_dest = 4'd3; tick();
    ex_opcode = NOP; ex_data = 32'h66; ex_dest = 4'd4; tick();
    ex_opcode = 5'd31; ex_data = 32'h77; ex_dest = 4'd7; tick();
    ex_valid = 0;
    tick();
    @(negedge clk);
    chk("hold_wb_addr", {28'b0, wb_addr}, 32'd2);
    chk("hold_wb_data", wb_data, 32'd2);

    // CMP keeps only the low two bits
    wbq.push_back('{4'd9, 32'h3});
    issue(CMP, 32'hFFFF_FFFF, 0, 4'd9);
    tick(); tick();

    chk("wbq_drained", wbq.size(), 0);
    chk("mrq_drained", mrq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
